// File: rtl/timer_core.sv
// timer_core: MM:SS BCD count engine driven by an external control-FSM state code.
// Supports up-free, down-from-preset, up-to-preset and down-from-max modes,
// with a prescaler producing one count advance every TICK_DIV clocks.
module timer_core #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  state,
  input  logic [1:0]  mode,
  input  logic [15:0] preset,
  output logic [15:0] digits,
  output logic        tick,
  output logic        done
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_RUN   = 3'b001;
  localparam logic [2:0] ST_PAUSE = 3'b010;
  localparam logic [2:0] ST_ARM   = 3'b011;
  localparam logic [2:0] ST_CLR   = 3'b100;
  localparam logic [2:0] ST_HOLD  = 3'b101;

  localparam logic [1:0] MODE_UP_FREE   = 2'b00;
  localparam logic [1:0] MODE_DN_PRESET = 2'b01;
  localparam logic [1:0] MODE_UP_PRESET = 2'b10;
  localparam logic [1:0] MODE_DN_MAX    = 2'b11;

  localparam logic [15:0] BCD_ZERO = 16'h0000;
  localparam logic [15:0] BCD_MAX  = 16'h9959;

  logic [15:0]   r_digits;
  logic          r_tick;
  logic          r_done;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_mode;
  logic [15:0]   r_preset;

  logic [15:0] w_sanitised;
  logic [15:0] w_start;
  logic [15:0] w_term;
  logic [15:0] w_next;
  logic        w_at_term;

  // Clamp each BCD digit into its legal range (minutes 0-9, tens of seconds 0-5).
  function automatic logic [15:0] f_sanitise(input logic [15:0] p);
    logic [3:0] m1, m0, s1, s0;
    m1 = (p[15:12] > 4'd9) ? 4'd9 : p[15:12];
    m0 = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
    s1 = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
    s0 = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    return {m1, m0, s1, s0};
  endfunction

  // One second later in MM:SS BCD; 99:59 holds, though the terminal check stops it first.
  function automatic logic [15:0] f_up(input logic [15:0] d);
    logic [15:0] n;
    n = d;
    if (d[3:0] < 4'd9) begin
      n[3:0] = d[3:0] + 4'd1;
    end else begin
      n[3:0] = 4'd0;
      if (d[7:4] < 4'd5) begin
        n[7:4] = d[7:4] + 4'd1;
      end else begin
        n[7:4] = 4'd0;
        if (d[11:8] < 4'd9) begin
          n[11:8] = d[11:8] + 4'd1;
        end else begin
          n[11:8] = 4'd0;
          if (d[15:12] < 4'd9) n[15:12] = d[15:12] + 4'd1;
          else                 n = d;
        end
      end
    end
    return n;
  endfunction

  // One second earlier in MM:SS BCD; 00:00 holds.
  function automatic logic [15:0] f_down(input logic [15:0] d);
    logic [15:0] n;
    n = d;
    if (d[3:0] != 4'd0) begin
      n[3:0] = d[3:0] - 4'd1;
    end else begin
      n[3:0] = 4'd9;
      if (d[7:4] != 4'd0) begin
        n[7:4] = d[7:4] - 4'd1;
      end else begin
        n[7:4] = 4'd5;
        if (d[11:8] != 4'd0) begin
          n[11:8] = d[11:8] - 4'd1;
        end else begin
          n[11:8] = 4'd9;
          if (d[15:12] != 4'd0) n[15:12] = d[15:12] - 4'd1;
          else                  n = d;
        end
      end
    end
    return n;
  endfunction

  // Start value from the live inputs (used while loading), terminal from the latched copy.
  always_comb begin
    w_sanitised = f_sanitise(preset);
    w_start     = BCD_ZERO;
    w_term      = BCD_ZERO;
    w_next      = r_digits;
    case (mode)
      MODE_UP_FREE:   w_start = BCD_ZERO;
      MODE_DN_PRESET: w_start = w_sanitised;
      MODE_UP_PRESET: w_start = BCD_ZERO;
      default:        w_start = BCD_MAX;
    endcase
    case (r_mode)
      MODE_UP_FREE:   w_term = BCD_MAX;
      MODE_DN_PRESET: w_term = BCD_ZERO;
      MODE_UP_PRESET: w_term = r_preset;
      MODE_DN_MAX:    w_term = BCD_ZERO;
      default:        w_term = BCD_ZERO;
    endcase
    if (r_mode == MODE_UP_FREE || r_mode == MODE_UP_PRESET) w_next = f_up(r_digits);
    else                                                    w_next = f_down(r_digits);
    w_at_term = (r_digits == w_term);
  end

  // Count engine: load in IDLE/CLR, advance in RUN, hold in every other state code.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits <= '0;
      r_tick   <= 1'b0;
      r_done   <= 1'b0;
      r_presc  <= '0;
      r_mode   <= '0;
      r_preset <= '0;
    end else begin
      r_tick <= 1'b0;
      case (state)
        ST_IDLE, ST_CLR: begin
          r_mode   <= mode;
          r_preset <= w_sanitised;
          r_digits <= w_start;
          r_presc  <= '0;
          r_done   <= 1'b0;
        end
        ST_RUN: begin
          // A count already sitting on terminal completes without a tick.
          if (!r_done) begin
            if (w_at_term) begin
              r_done <= 1'b1;
            end else if (r_presc == PRESC_MAX) begin
              r_presc  <= '0;
              r_tick   <= 1'b1;
              r_digits <= w_next;
              r_done   <= (w_next == w_term);
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
        end
        ST_PAUSE, ST_ARM, ST_HOLD: ;
        default: ;
      endcase
    end
  end

  assign digits = r_digits;
  assign tick   = r_tick;
  assign done   = r_done;

endmodule

// File: tb/tb_timer_core.sv
// Self-checking bench for timer_core: directed scenarios followed by randomized
// state/mode/preset phases, all compared against a seconds-based reference model.
module tb_timer_core;

  localparam int TICK_DIV = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  st;
  logic [1:0]  mode;
  logic [15:0] preset;
  logic [15:0] digits;
  logic        tick;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: count held as whole seconds (0..5999).
  int       m_sec, m_psec, m_presc;
  logic [1:0] m_mode;
  logic     m_done, m_tick;

  timer_core #(.TICK_DIV(TICK_DIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .state  (st),
    .mode   (mode),
    .preset (preset),
    .digits (digits),
    .tick   (tick),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  function automatic int bcd2sec(input logic [15:0] p);
    int m1, m0, s1, s0;
    m1 = clampi(int'(p[15:12]), 9);
    m0 = clampi(int'(p[11:8]), 9);
    s1 = clampi(int'(p[7:4]), 5);
    s0 = clampi(int'(p[3:0]), 9);
    return m1 * 600 + m0 * 60 + s1 * 10 + s0;
  endfunction

  function automatic logic [15:0] sec2bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int start_sec(input logic [1:0] md, input int ps);
    case (md)
      2'd1:    return ps;
      2'd3:    return 5999;
      default: return 0;
    endcase
  endfunction

  function automatic int term_sec(input logic [1:0] md, input int ps);
    case (md)
      2'd0:    return 5999;
      2'd2:    return ps;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int t;
    if (reset) begin
      m_sec = 0; m_psec = 0; m_presc = 0; m_mode = 2'd0; m_done = 1'b0; m_tick = 1'b0;
    end else begin
      m_tick = 1'b0;
      case (st)
        3'd0, 3'd4: begin
          m_mode  = mode;
          m_psec  = bcd2sec(preset);
          m_sec   = start_sec(mode, m_psec);
          m_presc = 0;
          m_done  = 1'b0;
        end
        3'd1: begin
          t = term_sec(m_mode, m_psec);
          if (!m_done) begin
            if (m_sec == t) begin
              m_done = 1'b1;
            end else if (m_presc == TICK_DIV - 1) begin
              m_presc = 0;
              m_tick  = 1'b1;
              m_sec   = (m_mode == 2'd0 || m_mode == 2'd2) ? m_sec + 1 : m_sec - 1;
              if (m_sec == t) m_done = 1'b1;
            end else begin
              m_presc++;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the same edge, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("digits", digits, sec2bcd(m_sec));
    chk("done", {15'd0, done}, {15'd0, m_done});
    chk("tick", {15'd0, tick}, {15'd0, m_tick});
  endtask

  task automatic run(input logic [2:0] s, input int n);
    st = s;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int nt;
    int r, len;
    logic [31:0] rv;

    reset = 1'b1; st = 3'd1; mode = 2'd0; preset = 16'h0000;
    m_sec = 0; m_psec = 0; m_presc = 0; m_mode = 2'd0; m_done = 1'b0; m_tick = 1'b0;
    step(); step();
    chk("reset_digits", digits, 16'h0000);
    chk("reset_done", {15'd0, done}, 16'd0);
    reset = 1'b0;

    // Up-free: 240 RUN cycles give 60 ticks and one minute.
    mode = 2'd0;
    run(3'd0, 1);
    st = 3'd1; nt = 0;
    for (int i = 0; i < 240; i++) begin
      step();
      if (tick) nt++;
    end
    chk("upfree_ticks", 16'(nt), 16'd60);
    chk("upfree_digits", digits, 16'h0100);
    chk("upfree_done", {15'd0, done}, 16'd0);

    // Down from preset 00:02 reaches terminal at cycle 8, then freezes.
    mode = 2'd1; preset = 16'h0002;
    run(3'd0, 1);
    run(3'd1, 4);
    chk("dn_c4", digits, 16'h0001);
    run(3'd1, 4);
    chk("dn_c8", digits, 16'h0000);
    chk("dn_c8_done", {15'd0, done}, 16'd1);
    run(3'd1, 4);
    chk("dn_frozen", digits, 16'h0000);

    // Pause keeps the partial prescaler count.
    mode = 2'd0;
    run(3'd0, 1);
    run(3'd1, 6);
    chk("pause_pre", digits, 16'h0001);
    run(3'd2, 10);
    chk("pause_hold", digits, 16'h0001);
    run(3'd1, 1);
    chk("pause_resume1", digits, 16'h0001);
    run(3'd1, 1);
    chk("pause_resume2", digits, 16'h0002);

    // Start values, borrow chain and preset sanitising.
    mode = 2'd3;
    run(3'd0, 1);
    chk("dnmax_load", digits, 16'h9959);
    mode = 2'd1; preset = 16'h0100;
    run(3'd4, 1);
    run(3'd1, 4);
    chk("borrow", digits, 16'h0059);
    preset = 16'h0F7A;
    run(3'd0, 1);
    chk("sanitise", digits, 16'h0959);

    // Already at terminal on RUN entry: done with no tick.
    mode = 2'd2; preset = 16'h0000;
    run(3'd0, 1);
    st = 3'd1; nt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick) nt++;
    end
    chk("term0_done", {15'd0, done}, 16'd1);
    chk("term0_ticks", 16'(nt), 16'd0);

    // Reset mid-RUN at 00:12.
    mode = 2'd0;
    run(3'd0, 1);
    run(3'd1, 48);
    chk("pre_reset", digits, 16'h0012);
    reset = 1'b1;
    run(3'd1, 1);
    chk("midrun_reset", digits, 16'h0000);
    reset = 1'b0;

    // Randomized phases of states, modes and presets.
    for (int p = 0; p < 200; p++) begin
      r = $urandom_range(0, 99);
      reset = (r < 3);
      r = $urandom_range(0, 99);
      if      (r < 15) st = 3'd0;
      else if (r < 22) st = 3'd4;
      else if (r < 70) st = 3'd1;
      else if (r < 78) st = 3'd2;
      else if (r < 84) st = 3'd3;
      else if (r < 90) st = 3'd5;
      else             st = 3'($urandom_range(6, 7));
      mode = 2'($urandom_range(0, 3));
      rv = $urandom();
      if ($urandom_range(0, 3) == 0) preset = rv[15:0];
      else preset = {8'h00, 4'($urandom_range(0, 1)), rv[3:0]};
      len = (st == 3'd1) ? $urandom_range(1, 60) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if (st != 3'd0 && st != 3'd4) begin
          rv = $urandom();
          mode = rv[17:16];
          preset = rv[15:0];
        end
        step();
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
